tc21073_serial_sub_8: RTL and testbench
=======================================

Name: tc21073_serial_sub_8

Overview:
- Bit-serial subtractor: the inverse of the 8-bit ripple adder. Computes diff = a - b - bin, LSB first, one full-subtractor bit per clock.
- Start/busy/done handshake.
- Used where the adder's result is checked or reversed (e.g. recovering an operand) and area matters more than latency.
- Flags: borrow out, zero and signed overflow.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  borrow in; captured when start is accepted
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; results valid
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow out of MSB; 1 means unsigned a < b + bin
- zero  output  1  diff == 0
- ovf  output  1  signed (two's complement) overflow

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state to IDLE, bit counter to 0, internal borrow to 0.
  - Outputs diff=0, bout=0, zero=0, ovf=0, busy=0, done=0.
  - rst has priority over start and over every state, including mid-RUN; any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E0: load a_sh=a, b_sh=b, br=bin, cnt=0, next state RUN.
  - Otherwise stay in IDLE. Previous diff/bout/zero/ovf are held unchanged.
- RUN, each edge:
  - Bit computation: d = a_sh[0]^b_sh[0]^br; bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br).
  - Shift d into the MSB of the result shift register (result shifts right).
  - a_sh and b_sh shift right; br = bo; cnt increments.
  - At cnt == WIDTH-1, also latch brin_msb = old br (the borrow into the MSB), then go to DONE.
  - Exactly WIDTH RUN edges: E1..E_WIDTH.
- DONE, one cycle:
  - done=1, busy=1.
  - diff = result register; bout = br; zero = (result == 0); ovf = brin_msb ^ br.
  - These four outputs are registered on entry to DONE and held stable until the next accepted start reaches DONE.
  - Next edge: go to IDLE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the start edge. The earliest next start is accepted at E_WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- start during RUN or DONE is ignored; it is not queued. Inputs a, b, bin may change freely after E0.
- All arithmetic is modulo 2^WIDTH. No X propagation: unused/held registers keep their last values.

Decomposition:
- Shared package tc21073_arith_pkg:
  - state enum sub_state_t {IDLE, RUN, DONE}
  - localparam CNT_W = $clog2(WIDTH)
- Sub-module full_subtractor1 (a, b, bin -> d, bout): the single-bit cell instantiated once in the datapath. It is the counterpart of the adder's full-adder cell and is reusable for a combinational ripple subtractor later.

Test Plan:
- a=0x50, b=0x30, bin=0, start pulse -> done exactly 8 cycles after the start edge; diff=0x20, bout=0, zero=0, ovf=0; busy high 9 cycles.
- a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, zero=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x80, b=0x00, bin=1 -> diff=0x7F, ovf=1. Then a=0x37, b=0x37, bin=0 -> diff=0x00, zero=1, ovf=0.
- Start again at cycle 3 of RUN with different operands -> ignored; first result unchanged. Results held after done until the next result; start at E_WIDTH+2 is accepted.
- rst=1 at RUN cycle 4 -> next cycle state IDLE, all outputs 0, no done pulse. A fresh start afterward gives the correct result.
- Random 1000 operand/bin sets: compare against the reference model a-b-bin. Round trip: tc21073_adder_8(diff, b, bin) returns a whenever bout=0.

Source files
------------

// File: rtl/tc21073_arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
package tc21073_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Returns {borrow_out, difference} for one full-subtractor bit.
  function automatic logic [1:0] fsub_bit(input logic a, input logic b, input logic bin);
    logic d;
    logic bo;
    d  = a ^ b ^ bin;
    bo = (~a & b) | (~(a ^ b) & bin);
    return {bo, d};
  endfunction

endpackage

// File: rtl/tc21073_serial_sub_8_fs.sv
// Single-bit full subtractor cell, reusable for a combinational ripple subtractor.
module full_subtractor1
  import tc21073_arith_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic [1:0] w_res;

  assign w_res  = fsub_bit(i_a, i_b, i_bin);
  assign o_d    = w_res[0];
  assign o_bout = w_res[1];

endmodule

// File: rtl/tc21073_serial_sub_8.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with start/busy/done handshake and borrow/zero/overflow flags.
module tc21073_serial_sub_8
  import tc21073_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_zero,
  output logic             o_ovf
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  sub_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_br;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor1 u_fs (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_bo)
  );

  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  // Control FSM, serial datapath and registered result flags.
  // On the last RUN edge r_br still holds the borrow into the MSB, so
  // overflow is taken directly as that borrow xor the final borrow out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_diff  <= '0;
      o_bout  <= 1'b0;
      o_zero  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_br    <= i_bin;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            o_busy <= 1'b0;
          end
        end
        RUN: begin
          r_res  <= w_res_next;
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_br   <= w_bo;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            o_diff  <= w_res_next;
            o_bout  <= w_bo;
            o_zero  <= (w_res_next == '0);
            o_ovf   <= r_br ^ w_bo;
            o_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc21073_serial_sub_8.sv
// Scoreboard bench for the bit-serial subtractor: directed plan cases plus random operands.
module tb_tc21073_serial_sub_8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       zero;
  logic       ovf;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
    int         start_cyc;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  tc21073_serial_sub_8 #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_diff  (diff),
    .o_bout  (bout),
    .o_zero  (zero),
    .o_ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
    exp_t e;
    int full;
    int sfull;
    full   = int'(ma) - int'(mb) - int'(mbin);
    sfull  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    e.a    = ma;
    e.b    = mb;
    e.bin  = mbin;
    e.diff = full[7:0];
    e.bout = (full < 0);
    e.zero = (full[7:0] == 8'h00);
    e.ovf  = (sfull > 127) || (sfull < -128);
    e.start_cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc - e.start_cyc, 8);
        check("diff", int'(diff), int'(e.diff));
        check("bout", int'(bout), int'(e.bout));
        check("zero", int'(zero), int'(e.zero));
        check("ovf", int'(ovf), int'(e.ovf));
        check("busy_at_done", int'(busy), 1);
        if (!bout)
          check("round_trip", int'(diff + e.b + {7'd0, e.bin}), int'(e.a));
      end
    end
  end

  // mode 0: normal, 1: extra start at RUN cycle 3, 2: reset at RUN cycle 4
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin, input int mode);
    exp_t e;
    int   nbusy;
    e = model(ta, tb_, tbin);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    e.start_cyc = cyc;
    if (mode != 2) begin
      q.push_back(e);
      last_exp = e;
    end
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_flags", int'({diff, bout, zero, ovf}), 0);
        break;
      end
      if (!busy) break;
      nbusy++;
      if (mode == 1 && nbusy == 3) begin
        start = 1'b1; a = ~ta; b = tb_ ^ 8'h5A; bin = ~tbin;
      end
      if (mode == 2 && nbusy == 4) rst = 1'b1;
    end
    if (mode != 2) begin
      check("busy_cycles", nbusy, 9);
      check("hold_diff", int'(diff), int'(last_exp.diff));
      check("hold_flags", int'({bout, zero, ovf}), int'({last_exp.bout, last_exp.zero, last_exp.ovf}));
    end else begin
      repeat (12) @(negedge clk);
      check("rst_no_done_busy", int'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_out", int'({diff, bout, zero, ovf}), 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h50, 8'h30, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b0, 0);
    do_op(8'h80, 8'h00, 1'b1, 0);
    do_op(8'h37, 8'h37, 1'b0, 0);
    do_op(8'hC3, 8'h1E, 1'b1, 1);
    do_op(8'h7F, 8'hFF, 1'b0, 0);
    do_op(8'h12, 8'h34, 1'b1, 2);
    do_op(8'hA5, 8'h5A, 1'b0, 0);
    for (int i = 0; i < 1000; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 0);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
